// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   state_t : arbiter FSM state (IDLE: memory free, BURST: accelerator owns the port)
//   owner_t : which requester drives the memory port in the current cycle
//   WORD_BYTES : byte stride between consecutive burst beats
package dmem_arb_pkg;

   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      CORE = 2'd1,
      ACC  = 2'd2
   } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Accelerator load-store burst port.
//   acc_req/acc_we/acc_addr/acc_len : burst request, held until acc_gnt
//   acc_wdata                       : write data for the current beat
//   acc_gnt                         : burst accepted, beat 0 on the memory port
//   acc_beat                        : a beat is on the memory port this cycle
//   acc_rdata                       : read data for the current beat
//   acc_done                        : final beat of the burst
// master = accelerator side, slave = arbiter side.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
);
   logic              acc_req;
   logic              acc_we;
   logic [ADDR_W-1:0] acc_addr;
   logic [LEN_W-1:0]  acc_len;
   logic [DATA_W-1:0] acc_wdata;
   logic              acc_gnt;
   logic              acc_beat;
   logic [DATA_W-1:0] acc_rdata;
   logic              acc_done;

   modport master (
      output acc_req, acc_we, acc_addr, acc_len, acc_wdata,
      input  acc_gnt, acc_beat, acc_rdata, acc_done
   );

   modport slave (
      input  acc_req, acc_we, acc_addr, acc_len, acc_wdata,
      output acc_gnt, acc_beat, acc_rdata, acc_done
   );
endinterface

// File: rtl/dmem_arb_burst_gen.sv
// dmem_arb_burst_gen
// Address/beat sequencer for accelerator bursts.
//   clk, rst : clock, synchronous active-low reset
//   load     : grant cycle; latch base+WORD_BYTES as the beat-1 address and len
//   advance  : a burst beat was issued; step address and beat count
//   base,len : burst base address and beats-minus-one, sampled on load
//   addr     : address of the current burst beat (wraps mod 2^ADDR_W)
//   last     : current beat is the final one
//   beat     : index of the current beat (1..len while in a burst)
module dmem_arb_burst_gen
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              advance,
   input  logic [ADDR_W-1:0] base,
   input  logic [LEN_W-1:0]  len,
   output logic [ADDR_W-1:0] addr,
   output logic              last,
   output logic [LEN_W-1:0]  beat
);

   logic [ADDR_W-1:0] addr_r;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  beat_r;

   // Beat address, length and beat counter registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_r <= {ADDR_W{1'b0}};
         len_r  <= {LEN_W{1'b0}};
         beat_r <= {LEN_W{1'b0}};
      end else if (load) begin
         // Beat 0 goes out in the grant cycle from the live request, so the
         // latched address already points at beat 1.
         addr_r <= base + ADDR_W'(WORD_BYTES);
         len_r  <= len;
         beat_r <= LEN_W'(1);
      end else if (advance) begin
         addr_r <= addr_r + ADDR_W'(WORD_BYTES);
         beat_r <= beat_r + LEN_W'(1);
      end else begin
         addr_r <= addr_r;
         len_r  <= len_r;
         beat_r <= beat_r;
      end
   end

   assign addr = addr_r;
   assign beat = beat_r;
   assign last = (beat_r == len_r);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the core MEM stage (port C,
// single-cycle accesses) and the accelerator burst port (port A,
// non-preemptible word bursts). Port A gains priority after MAX_WAIT
// refused cycles.
//   clk, rst          : clock, synchronous active-low reset
//   core_*            : core request, store data, load data and stall
//   acc               : accelerator burst port (dmem_arbiter_if.slave)
//   mem_*             : data_mem write enable, address, write data, read data
//   perf_core_stalls  : stalled core cycles  (DMEM_ARB_PERF_EN only, else 0)
//   perf_acc_beats    : accelerator beats    (DMEM_ARB_PERF_EN only, else 0)
// Optional feature macro: DMEM_ARB_PERF_EN
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LEN_W    = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   dmem_arbiter_if.slave     acc,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       perf_core_stalls,
   output logic [31:0]       perf_acc_beats
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   state_t            state_r;
   state_t            state_nxt_s;
   owner_t            owner_s;
   logic [WAIT_W-1:0] wait_r;
   logic              we_r;
   logic              acc_win_s;
   logic              bg_advance_s;
   logic [ADDR_W-1:0] bg_addr_s;
   logic              bg_last_s;
   logic [LEN_W-1:0]  bg_beat_s;

   // Port A wins an idle port when the core is quiet or has starved it long enough.
   assign acc_win_s = rst && (state_r == IDLE) && acc.acc_req &&
                      (!core_req || (wait_r >= WAIT_W'(MAX_WAIT)));

   assign bg_advance_s = rst && (state_r == BURST);

   dmem_arb_burst_gen #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_burst_gen (
      .clk     (clk),
      .rst     (rst),
      .load    (acc_win_s),
      .advance (bg_advance_s),
      .base    (acc.acc_addr),
      .len     (acc.acc_len),
      .addr    (bg_addr_s),
      .last    (bg_last_s),
      .beat    (bg_beat_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (acc_win_s && (acc.acc_len != {LEN_W{1'b0}})) begin
               state_nxt_s = BURST;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BURST: begin
            // A zero beat index can only mean a corrupted sequencer; leave the burst.
            if (bg_last_s || (bg_beat_s == {LEN_W{1'b0}})) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = BURST;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs: port ownership and the memory-port mux.
   always_comb begin
      owner_s      = NONE;
      mem_we       = 1'b0;
      mem_addr     = {ADDR_W{1'b0}};
      mem_wdata    = {DATA_W{1'b0}};
      acc.acc_gnt  = 1'b0;
      acc.acc_done = 1'b0;
      case (state_r)
         IDLE: begin
            if (!rst) begin
               owner_s = NONE;
            end else if (acc_win_s) begin
               owner_s      = ACC;
               acc.acc_gnt  = 1'b1;
               acc.acc_done = (acc.acc_len == {LEN_W{1'b0}});
               mem_we       = acc.acc_we;
               mem_addr     = acc.acc_addr;
               mem_wdata    = acc.acc_wdata;
            end else if (core_req) begin
               owner_s   = CORE;
               mem_we    = core_we;
               mem_addr  = core_addr;
               mem_wdata = core_wdata;
            end else begin
               owner_s = NONE;
            end
         end
         BURST: begin
            if (!rst) begin
               owner_s = NONE;
            end else begin
               owner_s      = ACC;
               acc.acc_done = bg_last_s;
               mem_we       = we_r;
               mem_addr     = bg_addr_s;
               mem_wdata    = acc.acc_wdata;
            end
         end
         default: owner_s = NONE;
      endcase
   end

   assign acc.acc_beat  = (owner_s == ACC);
   assign core_stall    = core_req && (owner_s != CORE);
   assign core_rdata    = mem_rdata;
   assign acc.acc_rdata = mem_rdata;

   // Burst direction latched at grant so mid-burst acc_we changes are ignored.
   always_ff @(posedge clk) begin
      if (!rst) begin
         we_r <= 1'b0;
      end else if (acc_win_s) begin
         we_r <= acc.acc_we;
      end else begin
         we_r <= we_r;
      end
   end

   // Starvation counter for port A, saturating at MAX_WAIT.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_r <= {WAIT_W{1'b0}};
      end else if (!acc.acc_req || acc_win_s) begin
         wait_r <= {WAIT_W{1'b0}};
      end else if (wait_r < WAIT_W'(MAX_WAIT)) begin
         wait_r <= wait_r + WAIT_W'(1);
      end else begin
         wait_r <= wait_r;
      end
   end

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_stall_r;
   logic [31:0] perf_beat_r;

   // Free-running, wrapping performance counters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_stall_r <= 32'd0;
         perf_beat_r  <= 32'd0;
      end else begin
         perf_stall_r <= perf_stall_r + (core_stall ? 32'd1 : 32'd0);
         perf_beat_r  <= perf_beat_r + (acc.acc_beat ? 32'd1 : 32'd0);
      end
   end

   assign perf_core_stalls = perf_stall_r;
   assign perf_acc_beats   = perf_beat_r;
`else
   assign perf_core_stalls = 32'd0;
   assign perf_acc_beats   = 32'd0;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the core MEM stage (port C) and a matrix/vector accelerator load-store port (port A).
- Core accesses are single-cycle. Accelerator accesses are non-preemptible word bursts.
- Sits between pipeline_EXEtoMEM / MEM stage, the accelerator, and data_mem.
- Emits a core stall that the hazard unit ORs into its existing stall.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data word width
- LEN_W, 4, burst length field width; a burst is acc_len+1 beats, max 16
- MAX_WAIT, 8, cycles port A may be refused before it gains priority over port C

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-low (0 = reset)
- core_req  in  1  core memory access this cycle (load or store)
- core_we  in  1  core store
- core_addr  in  ADDR_W  core byte address
- core_wdata  in  DATA_W  core store data
- core_rdata  out  DATA_W  core load data, combinational from mem_rdata
- core_stall  out  1  core access refused this cycle
- acc_req  in  1  burst request; held with addr/len/we until acc_gnt
- acc_we  in  1  burst is write
- acc_addr  in  ADDR_W  burst base byte address, word aligned
- acc_len  in  LEN_W  beats minus one
- acc_wdata  in  DATA_W  write data for the current beat
- acc_gnt  out  1  one-cycle pulse; burst accepted, beat 0 issued
- acc_beat  out  1  a beat is on the memory port this cycle
- acc_rdata  out  DATA_W  read data for the current beat
- acc_done  out  1  pulse on the final beat
- mem_we  out  1  to data_mem WDME
- mem_addr  out  ADDR_W  to data_mem A
- mem_wdata  out  DATA_W  to data_mem WD
- mem_rdata  in  DATA_W  from data_mem RD (combinational read)
- perf_core_stalls  out  32  stalled core cycles (optional feature)
- perf_acc_beats  out  32  accelerator beats issued (optional feature)

Behaviour:
- Reset (rst=0 at posedge): state IDLE, beat counter 0, wait counter 0, latched address/len/we cleared.
  - All pulse outputs 0; core_stall=core_req; mem_we=0.
- States:
  - IDLE: memory free.
  - BURST: accelerator owns the port; beats 1..len remain.
- IDLE arbitration, combinational in the same cycle:
  - Port A wins if acc_req and (!core_req or wait_cnt>=MAX_WAIT). Otherwise port C wins if core_req.
  - Port C win: mem_* driven from core_*; core_stall=0; core_rdata=mem_rdata. Stay IDLE.
  - Port A win: acc_gnt=1, acc_beat=1; mem_addr=acc_addr, mem_we=acc_we, mem_wdata=acc_wdata; acc_rdata=mem_rdata.
    - Latch base+4 and len. core_stall=core_req.
    - If acc_len==0: acc_done=1, stay IDLE. Else go to BURST with beat=1.
- BURST, each cycle:
  - One beat at the latched address: acc_beat=1; the address increments by 4 mod 2^ADDR_W.
  - acc_wdata is sampled every beat; the accelerator advances data on acc_beat.
  - core_stall=core_req.
  - On beat==len: acc_done=1, return to IDLE.
  - A new acc_req is not sampled until IDLE. No back-to-back grant without one IDLE cycle.
- Wait counter:
  - Increments each cycle acc_req=1 and port A is not granted; saturates at MAX_WAIT.
  - Cleared on acc_gnt or acc_req=0.
- No memory request: mem_we=0, mem_addr=0, mem_wdata=0.
- mem_we is never 1 for a denied requester.
- Reset mid-burst: abort to IDLE, no acc_done, the remaining beats are dropped.
- acc_len/acc_addr changes while waiting: the values sampled in the grant cycle are used.

Optional Feature:
- DMEM_ARB_PERF_EN defined:
  - perf_core_stalls increments each cycle core_stall=1.
  - perf_acc_beats increments each cycle acc_beat=1.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- dmem_arb_pkg:
  - state enum: IDLE, BURST
  - WORD_BYTES=4
  - owner enum: NONE, CORE, ACC
- Sub-module dmem_arb_burst_gen:
  - Latches base and len on load.
  - Outputs addr, last flag, and beat count.
  - Steps on advance.

Test Plan:
1. core_req=1, we=1, addr=0x100, wdata=0xDEADBEEF with acc idle -> core_stall=0, mem_we=1 same cycle. A read the next cycle returns 0xDEADBEEF.
2. acc_req, addr=0x200, len=3, we=0 with the core idle -> acc_gnt in cycle 0; beats at 0x200/0x204/0x208/0x20C on 4 consecutive cycles; acc_done on the 4th.
3. core_req and acc_req both held high -> core is served for 8 cycles; on the 9th the accelerator is granted and core_stall=1 for the whole burst. Then the core resumes.
4. Burst len=15 starting at 0xFFFFFFF8 -> addresses wrap to 0x0 after 0xFFFFFFFC. 16 beats, one acc_done.
5. rst=0 during beat 2 of a len=5 burst -> next cycle IDLE, acc_beat=0, no acc_done, the core is served immediately.
6. With DMEM_ARB_PERF_EN, after scenario 3 -> perf_core_stalls=4 (len=3) and perf_acc_beats=4. Without the macro, both read 0.
